// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared op encoding, SEW constants and product width helpers for
//               the multiplier result formatter. Optional MULT_FMT_VSMUL_EN
//               widens the op field to carry VSMUL.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

`ifdef MULT_FMT_VSMUL_EN
  localparam int OP_W = 3;
`else
  localparam int OP_W = 2;
`endif

  typedef enum logic [OP_W-1:0] {
    OP_MUL    = OP_W'(0),
    OP_MULH   = OP_W'(1),
    OP_MULHU  = OP_W'(2),
`ifdef MULT_FMT_VSMUL_EN
    OP_MULHSU = OP_W'(3),
    OP_VSMUL  = OP_W'(4)
`else
    OP_MULHSU = OP_W'(3)
`endif
  } op_e;

  localparam int SEW16 = 16;
  localparam int SEW32 = 32;

  function automatic int p16_w(input int iw);
    return 2 * iw - 1;
  endfunction

  function automatic int p32_w(input int iw);
    return 2 * iw + 31;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_result_fmt_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_result_fmt_if
// Description : Issue, multiplier product and result handshake bundle for
//               mult_result_fmt. Op field width follows MULT_FMT_VSMUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_result_fmt_if #(
  parameter int INPUT_WIDTH = 18,
  parameter int TAG_W       = 5
) ();
  localparam int P16_W = mult_pkg::p16_w(INPUT_WIDTH);
  localparam int P32_W = mult_pkg::p32_w(INPUT_WIDTH);

  logic                      in_valid;
  logic                      in_ready;
  logic [mult_pkg::OP_W-1:0] in_op;
  logic                      in_sew32;
  logic [TAG_W-1:0]          in_tag;
  logic [P16_W-1:0]          mult16_p0;
  logic [P16_W-1:0]          mult16_p1;
  logic [P32_W-1:0]          mult32;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_data;
  logic [TAG_W-1:0]          out_tag;
  logic                      out_sat;

  modport master (
    output in_valid, in_op, in_sew32, in_tag, mult16_p0, mult16_p1, mult32, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_sat
  );

  modport slave (
    input  in_valid, in_op, in_sew32, in_tag, mult16_p0, mult16_p1, mult32, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_credit.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_credit
// Description : In-order FIFO with a registered head word and an exposed
//               occupancy count for upstream credit accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_credit #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [OCC_W-1:0]      occupancy
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_remain;
  logic [WIDTH-1:0] r_head;
  logic             w_pop;
  logic             w_load_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid  = (r_occ != '0);
  assign out_data   = r_head;
  assign occupancy  = r_occ;
  assign w_pop      = out_valid && pop_ready;
  assign w_rptr_nxt = w_pop ? ptr_inc(r_rptr) : r_rptr;
  assign w_remain   = w_pop ? r_occ - OCC_W'(1) : r_occ;
  // Head reloads only when it changes; an empty FIFO keeps the last word.
  assign w_load_head = (w_pop || (r_occ == '0)) && (push || (w_remain != '0));

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_head <= '0;
    end else begin
      if (push) r_wptr <= ptr_inc(r_wptr);
      r_rptr <= w_rptr_nxt;
      case ({push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_load_head) r_head <= (w_remain == '0) ? push_data : r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && !w_pop && (r_occ == OCC_W'(DEPTH))));
  end
endmodule
`default_nettype wire

// File: rtl/mult_result_fmt.sv
`default_nettype none
// ============================================================================
// Module      : mult_result_fmt
// Description : Tracks multiplies through the fixed-latency multiplier, selects
//               product halves per op/SEW and buffers results behind credits.
//               MULT_FMT_VSMUL_EN adds VSMUL rounding and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_result_fmt
  import mult_pkg::*;
#(
  parameter int INPUT_WIDTH = 18,
  parameter int MULT_LAT    = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 5
) (
  input wire logic          clk,
  input wire logic          rst_n,
  mult_result_fmt_if.slave  bus
);
  localparam int P16_W = p16_w(INPUT_WIDTH);
  localparam int P32_W = p32_w(INPUT_WIDTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + MULT_LAT + 1);
  localparam int LAST  = MULT_LAT - 1;
`ifdef MULT_FMT_VSMUL_EN
  localparam int PAY_W = 33 + TAG_W;
`else
  localparam int PAY_W = 32 + TAG_W;
`endif

  logic [MULT_LAT-1:0] r_pv;
  op_e                 r_pop  [MULT_LAT];
  logic [MULT_LAT-1:0] r_psew;
  logic [TAG_W-1:0]    r_ptag [MULT_LAT];
  logic                w_accept;
  logic [SUM_W-1:0]    w_used;
  logic [OCC_W-1:0]    w_occ;
  logic [31:0]         w_fmt_data;
  logic [PAY_W-1:0]    w_push_data;
  logic [PAY_W-1:0]    w_head;
  op_e                 w_fin_op;
  logic                w_fin_sew32;
  logic                w_unused;

  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_fin_op    = r_pop[LAST];
  assign w_fin_sew32 = r_psew[LAST];

  // Credits cover both buffered results and products still in the multiplier.
  always_comb begin
    w_used = SUM_W'(w_occ);
    for (int i = 0; i < MULT_LAT; i++) w_used = w_used + SUM_W'(r_pv[i]);
  end
  assign bus.in_ready = (w_used < SUM_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv   <= '0;
      r_psew <= '0;
      for (int i = 0; i < MULT_LAT; i++) begin
        r_pop[i]  <= OP_MUL;
        r_ptag[i] <= '0;
      end
    end else begin
      r_pv[0]   <= w_accept;
      r_pop[0]  <= op_e'(bus.in_op);
      r_psew[0] <= bus.in_sew32;
      r_ptag[0] <= bus.in_tag;
      for (int i = 1; i < MULT_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pop[i]  <= r_pop[i-1];
        r_psew[i] <= r_psew[i-1];
        r_ptag[i] <= r_ptag[i-1];
      end
    end
  end

`ifdef MULT_FMT_VSMUL_EN
  localparam logic signed [P16_W:0] RND16 = (P16_W+1)'(1 << (SEW16 - 2));
  localparam logic signed [P16_W:0] MAX16 = (P16_W+1)'(32767);
  localparam logic signed [P16_W:0] MIN16 = (P16_W+1)'(-32768);
  localparam logic signed [P32_W:0] RND32 = (P32_W+1)'(1 << (SEW32 - 2));
  localparam logic signed [P32_W:0] MAX32 = (P32_W+1)'(32'sh7FFF_FFFF);
  localparam logic signed [P32_W:0] MIN32 = (P32_W+1)'(32'sh8000_0000);

  logic [16:0] w_l0;
  logic [16:0] w_l1;
  logic        w_fmt_sat;

  function automatic logic [16:0] vsmul16(input logic [P16_W-1:0] p);
    logic signed [P16_W:0] r;
    r = ($signed({p[P16_W-1], p}) + RND16) >>> (SEW16 - 1);
    if (r > MAX16) return {1'b1, 16'h7FFF};
    if (r < MIN16) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic logic [32:0] vsmul32(input logic [P32_W-1:0] p);
    logic signed [P32_W:0] r;
    r = ($signed({p[P32_W-1], p}) + RND32) >>> (SEW32 - 1);
    if (r > MAX32) return {1'b1, 32'h7FFF_FFFF};
    if (r < MIN32) return {1'b1, 32'h8000_0000};
    return {1'b0, r[31:0]};
  endfunction
`endif

  always_comb begin
    w_fmt_data = '0;
    if (w_fin_sew32)
      w_fmt_data = (w_fin_op == OP_MUL) ? bus.mult32[31:0] : bus.mult32[63:32];
    else
      w_fmt_data = (w_fin_op == OP_MUL) ? {bus.mult16_p0[15:0],  bus.mult16_p1[15:0]}
                                        : {bus.mult16_p0[31:16], bus.mult16_p1[31:16]};
`ifdef MULT_FMT_VSMUL_EN
    w_fmt_sat = 1'b0;
    w_l0      = vsmul16(bus.mult16_p0);
    w_l1      = vsmul16(bus.mult16_p1);
    if (w_fin_op == OP_VSMUL) begin
      if (w_fin_sew32) begin
        {w_fmt_sat, w_fmt_data} = vsmul32(bus.mult32);
      end else begin
        w_fmt_data = {w_l0[15:0], w_l1[15:0]};
        w_fmt_sat  = w_l0[16] | w_l1[16];
      end
    end
`endif
  end

`ifdef MULT_FMT_VSMUL_EN
  assign w_push_data = {w_fmt_sat, r_ptag[LAST], w_fmt_data};
  assign bus.out_sat = w_head[PAY_W-1];
`else
  assign w_push_data = {r_ptag[LAST], w_fmt_data};
  assign bus.out_sat = 1'b0;
`endif
  assign bus.out_data = w_head[31:0];
  assign bus.out_tag  = w_head[32 +: TAG_W];

  assign w_unused = ^{bus.mult32[P32_W-1:64], bus.mult16_p0[P16_W-1:32],
                      bus.mult16_p1[P16_W-1:32]};

  sync_fifo_credit #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_pv[LAST]),
    .push_data (w_push_data),
    .pop_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (w_head),
    .occupancy (w_occ)
  );
endmodule
`default_nettype wire

// File: tb/tb_mult_result_fmt.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_result_fmt
// Description : Directed and random checks of mult_result_fmt against a
//               two-cycle multiplier model and an arithmetic result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_result_fmt;
  import mult_pkg::*;

  localparam int INPUT_WIDTH = 18;
  localparam int MULT_LAT    = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int TAG_W       = 5;
  localparam int P16_W       = p16_w(INPUT_WIDTH);
  localparam int P32_W       = p32_w(INPUT_WIDTH);

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             sat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_result_fmt_if #(.INPUT_WIDTH(INPUT_WIDTH), .TAG_W(TAG_W)) ifc ();

  mult_result_fmt #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .MULT_LAT    (MULT_LAT),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TAG_W       (TAG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int accepted    = 0;
  int nout        = 0;
  exp_t cur_exp;
  exp_t expq[$];
  logic [31:0]      outlog[$];
  logic [TAG_W-1:0] taglog[$];
  logic             satlog[$];

  logic signed [P16_W-1:0] cur_p0 = '0, cur_p1 = '0, s1_p0 = '0, s1_p1 = '0;
  logic signed [P32_W-1:0] cur_p32 = '0, s1_p32 = '0;

  // Multiplier stand-in: products appear two cycles after operands.
  always @(posedge clk) begin
    s1_p0         <= cur_p0;
    s1_p1         <= cur_p1;
    s1_p32        <= cur_p32;
    ifc.mult16_p0 <= s1_p0;
    ifc.mult16_p1 <= s1_p1;
    ifc.mult32    <= s1_p32;
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Reference result of one lane of width w: {sat, result}.
  function automatic logic [32:0] lane_res(input int op, input int w,
                                           input logic [31:0] x, input logic [31:0] y);
    longint vx, vy, p, r;
    bit sx, sy;
    sx = (op != 2);
    sy = (op != 2) && (op != 3);
    if (w == 16) begin
      vx = sx ? longint'($signed(x[15:0])) : longint'(x[15:0]);
      vy = sy ? longint'($signed(y[15:0])) : longint'(y[15:0]);
    end else begin
      vx = sx ? longint'($signed(x)) : longint'(x);
      vy = sy ? longint'($signed(y)) : longint'(y);
    end
    p = vx * vy;
    if (op == 4) begin
      r = (p + (longint'(1) << (w - 2))) >>> (w - 1);
      if (r > ((longint'(1) << (w - 1)) - 1))
        return (w == 16) ? 33'h1_0000_7FFF : 33'h1_7FFF_FFFF;
      return (w == 16) ? {17'b0, r[15:0]} : {1'b0, r[31:0]};
    end
    r = (op == 0) ? p : (p >>> w);
    return (w == 16) ? {17'b0, r[15:0]} : {1'b0, r[31:0]};
  endfunction

  task automatic drive(input bit v, input int op, input bit sew32,
                       input logic [TAG_W-1:0] tag, input logic [31:0] a, input logic [31:0] b);
    bit sx, sy;
    logic [32:0] l0, l1;
    logic signed [P32_W-1:0] ea, eb;
    logic signed [P16_W-1:0] ea0, eb0, ea1, eb1;
    sx = (op != 2);
    sy = (op != 2) && (op != 3);
    ifc.in_valid = v;
    ifc.in_op    = OP_W'(op);
    ifc.in_sew32 = sew32;
    ifc.in_tag   = tag;
    ea  = sx ? P32_W'($signed(a)) : P32_W'(a);
    eb  = sy ? P32_W'($signed(b)) : P32_W'(b);
    ea0 = sx ? P16_W'($signed(a[31:16])) : P16_W'(a[31:16]);
    eb0 = sy ? P16_W'($signed(b[31:16])) : P16_W'(b[31:16]);
    ea1 = sx ? P16_W'($signed(a[15:0])) : P16_W'(a[15:0]);
    eb1 = sy ? P16_W'($signed(b[15:0])) : P16_W'(b[15:0]);
    if (sew32) begin
      cur_p32 = ea * eb;
      cur_p0  = P16_W'({$urandom, $urandom});
      cur_p1  = P16_W'({$urandom, $urandom});
      l0      = lane_res(op, 32, a, b);
      cur_exp = '{data: l0[31:0], tag: tag, sat: l0[32]};
    end else begin
      cur_p0  = ea0 * eb0;
      cur_p1  = ea1 * eb1;
      cur_p32 = P32_W'({$urandom, $urandom, $urandom});
      l0      = lane_res(op, 16, {16'b0, a[31:16]}, {16'b0, b[31:16]});
      l1      = lane_res(op, 16, {16'b0, a[15:0]},  {16'b0, b[15:0]});
      cur_exp = '{data: {l0[15:0], l1[15:0]}, tag: tag, sat: l0[32] | l1[32]};
    end
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, '0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n && ifc.in_valid && ifc.in_ready) begin
      expq.push_back(cur_exp);
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  // Result monitor: head must match the oldest issued op every cycle it is valid.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid) begin
      if (expq.size() == 0) begin
        vectors++;
        assert (expq.size() != 0) else begin
          miscompares++;
          $error("FAIL spurious_out: observed out_valid=1 tag 0x%0h expected no result", ifc.out_tag);
        end
      end else begin
        check("out_data", 64'(ifc.out_data), 64'(expq[0].data));
        check("out_tag",  64'(ifc.out_tag),  64'(expq[0].tag));
        check("out_sat",  64'(ifc.out_sat),  64'(expq[0].sat));
        if (ifc.out_ready) begin
          void'(expq.pop_front());
          outlog.push_back(ifc.out_data);
          taglog.push_back(ifc.out_tag);
          satlog.push_back(ifc.out_sat);
          nout++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, n0;
    ifc.out_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(ifc.in_ready),  64'd1);
    check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("rst_out_data",  64'(ifc.out_data),  64'd0);
    check("rst_out_tag",   64'(ifc.out_tag),   64'd0);
    check("rst_out_sat",   64'(ifc.out_sat),   64'd0);
    rst_n = 1'b1;
    tick();

    // Latency: accept in t, visible in t+3.
    drive(1'b1, 0, 1'b0, 5'h01, {16'd3, 16'hFFFE}, {16'd5, 16'd7});
    tick();
    idle();
    tick();
    @(negedge clk);
    check("lat_t2_valid", 64'(ifc.out_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_t3_valid", 64'(ifc.out_valid), 64'd1);
    check("lat_t3_data",  64'(ifc.out_data),  64'h000F_FFF2);
    @(posedge clk);
    #1;

    // Back-to-back sew32 high halves.
    drive(1'b1, 1, 1'b1, 5'h02, 32'h8000_0000, 32'h8000_0000);
    tick();
    drive(1'b1, 2, 1'b1, 5'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    idle();
    repeat (4) tick();
    check("mulh_data",  64'(outlog[1]), 64'h4000_0000);
    check("mulhu_data", 64'(outlog[2]), 64'hFFFF_FFFE);
    check("b2b_tag0",   64'(taglog[1]), 64'h02);
    check("b2b_tag1",   64'(taglog[2]), 64'h03);

`ifdef MULT_FMT_VSMUL_EN
    drive(1'b1, 4, 1'b0, 5'h04, 32'h8000_8000, 32'h8000_8000);
    tick();
    drive(1'b1, 4, 1'b0, 5'h05, 32'h4000_4000, 32'h4000_4000);
    tick();
    idle();
    repeat (4) tick();
    check("vsmul_sat_data", 64'(outlog[outlog.size()-2]), 64'h7FFF_7FFF);
    check("vsmul_sat_flag", 64'(satlog[satlog.size()-2]), 64'd1);
    check("vsmul_rnd_data", 64'(outlog[outlog.size()-1]), 64'h2000_2000);
    check("vsmul_rnd_flag", 64'(satlog[satlog.size()-1]), 64'd0);
`endif

    // Backpressure: credits stop issue at FIFO_DEPTH, then drain in order.
    ifc.out_ready = 1'b0;
    acc0 = accepted;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, int'($urandom_range(0, 3)), 1'($urandom), 5'(8 + i), $urandom, $urandom);
      tick();
    end
    idle();
    @(negedge clk);
    check("bp_accepts",  64'(accepted - acc0), 64'd4);
    check("bp_in_ready", 64'(ifc.in_ready),    64'd0);
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b1;
    n0 = nout;
    repeat (6) tick();
    check("bp_drained", 64'(nout - n0),     64'd4);
    check("bp_q_empty", 64'(expq.size()),   64'd0);

    // Reset with two in flight and two buffered.
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 0, 1'b1, 5'(17 + i), $urandom | 32'h1, $urandom | 32'h1);
      tick();
    end
    idle();
    @(negedge clk);
    check("pre_rst_valid", 64'(ifc.out_valid), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("mid_rst_out_data",  64'(ifc.out_data),  64'd0);
    check("mid_rst_out_tag",   64'(ifc.out_tag),   64'd0);
    check("mid_rst_in_ready",  64'(ifc.in_ready),  64'd1);
    expq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    n0 = nout;
    repeat (6) tick();
    check("post_rst_no_emit", 64'(nout - n0), 64'd0);

    // Continuous random issue, one result per cycle.
    acc0 = accepted;
    n0   = nout;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, int'($urandom_range(0, 3)), 1'($urandom), 5'($urandom), $urandom, $urandom);
      tick();
    end
    idle();
    repeat (MULT_LAT + 1) tick();
    check("stream_accepts", 64'(accepted - acc0), 64'd100);
    check("stream_outputs", 64'(nout - n0),       64'd100);
    check("stream_q_empty", 64'(expq.size()),     64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
